scan_dec: RTL and testbench
===========================

Name: scan_dec

Overview:
Registered, parametrised binary-to-one-hot decoder with a built-in digit-scan sequencer, for time-multiplexed 7-segment and LED arrays. In manual mode it decodes a supplied select; in scan mode it steps through NUM_CH channels, holding each for DWELL clocks with an optional blanking gap to prevent ghosting. Outputs are active-high and sit between the display controller and the digit-enable drivers.

Parameters:
SEL_W, 4, select width; output width is 2**SEL_W.
NUM_CH, 16, channels used in scan mode; legal range 1..2**SEL_W.
DWELL, 1000, clocks each channel is driven per scan step; must be at least 1.
BLANK_CYC, 2, clocks all outputs are low between channels; 0 disables blanking.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
resetL  input  1  asynchronous active-low reset.
enable  input  1  high = run; low = outputs forced off.
scanMode  input  1  1 = auto scan, 0 = manual decode.
manSel  input  SEL_W  channel select used in manual mode.
selOut  output  2**SEL_W  registered one-hot channel enable; all-zero when idle or blanking.
curSel  output  SEL_W  registered binary index of the current or last-driven channel.
wrap  output  1  one-clock pulse when the scan returns from NUM_CH-1 to 0.
badSel  output  1  registered; high while manual mode is running and manSel >= NUM_CH.

Behaviour:
- Reset (resetL low, asynchronous): selOut=0, curSel=0, wrap=0, badSel=0, state=IDLE, dwell and blank counters=0. Release is synchronous to the next rising edge.
- States: IDLE, MANUAL, DRIVE, BLANK. All outputs are registered, so a change at any edge is visible after that edge.
- IDLE: selOut=0.
  - enable && !scanMode -> MANUAL.
  - enable && scanMode -> DRIVE with curSel=0, dwell counter=0.
- MANUAL:
  - Each edge: curSel<=manSel.
  - If manSel<NUM_CH: selOut<=onehot(manSel), badSel<=0.
  - Otherwise: selOut<=0, badSel<=1.
  - Latency from manSel to selOut is 1 clock.
- DRIVE:
  - selOut=onehot(curSel).
  - Dwell counter increments each clock; the state lasts exactly DWELL clocks.
  - On the last dwell clock: go to BLANK if BLANK_CYC>0, else advance directly.
- BLANK:
  - selOut=0, curSel holds.
  - Lasts exactly BLANK_CYC clocks, then advances.
- Advance:
  - curSel<=(curSel==NUM_CH-1) ? 0 : curSel+1, dwell counter cleared, state=DRIVE.
  - wrap=1 for exactly the first DRIVE clock of channel 0 reached via wrap-around; never on the initial entry from IDLE.
- NUM_CH=1: scan mode holds channel 0 continuously, apart from blank gaps. wrap pulses once per DWELL+BLANK_CYC period.
- enable low from any state: next edge -> IDLE, selOut=0, badSel=0, wrap=0, counters cleared, curSel holds.
- scanMode change while enabled:
  - scan->manual: next edge -> MANUAL with the manual decode applied.
  - manual->scan: next edge -> DRIVE at curSel=0 with a fresh dwell count; no wrap pulse.
- Counters are sized with $clog2 of DWELL and BLANK_CYC, with a minimum width of 1.
- curSel arithmetic is in SEL_W bits; wrap is explicit at NUM_CH-1, never natural overflow.
- Elaboration-time assertions check NUM_CH in 1..2**SEL_W and DWELL>=1.

Decomposition:
- Package scan_pkg holds the state enum (IDLE, MANUAL, DRIVE, BLANK) and the mode constants SCAN=1'b1 and MANUAL=1'b0.
- Sub-module onehot_dec is purely combinational, parametrised by SEL_W, with inputs sel and en and output the one-hot vector. Instantiate it once with explicit port mapping, feeding the next-state selOut register.

Test Plan:
- Reset mid-scan: SEL_W=2, NUM_CH=3, DWELL=4, BLANK_CYC=1, resetL pulsed low during DRIVE of channel 1 -> selOut=0000, curSel=0, wrap=0 immediately, without waiting for a clock edge.
- Scan sequence (same parameters), enable=1, scanMode=1 from IDLE -> selOut=0001 for 4 clocks, 0000 for 1, 0010 for 4, 0000 for 1, 0100 for 4, 0000 for 1, then 0001 with wrap=1 for that single first clock only.
- Manual decode: SEL_W=4, NUM_CH=10, manSel stepped through 0..15 -> selOut=onehot(manSel) one clock later for 0..9; selOut=0 with badSel=1 for 10..15.
- Blanking disabled: BLANK_CYC=0, NUM_CH=2, DWELL=3 -> selOut alternates 01 for 3 clocks and 10 for 3 clocks with no zero gap; wrap pulses every 6 clocks.
- Enable drop and mode switch: enable low during BLANK -> selOut=0 and IDLE with curSel held. Re-enable in manual with manSel=2 -> selOut=0100 after 1 clock. Switch to scan -> restart at channel 0 with no wrap pulse.
- NUM_CH=1, DWELL=2, BLANK_CYC=1 -> selOut pattern 1,1,0 repeating, with wrap on each return to the drive phase after the first.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types for the scan decoder: FSM state encoding and scan/manual mode constants.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_BLANK  = 2'd3
    } scan_state_e;

    localparam logic SCAN   = 1'b1;
    localparam logic MANUAL = 1'b0;

endpackage : scan_pkg

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with an enable.
// Zero latency; the output is all-zero whenever the enable is low.
module onehot_dec #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [(1<<SEL_W)-1:0] onehot
);

    localparam int OUT_W = 1 << SEL_W;

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = OUT_W'(1) << sel;
        end
    end

endmodule : onehot_dec

// File: rtl/scan_dec.sv
// Registered one-hot digit-enable decoder with manual select or timed auto-scan with blanking.
// All outputs are registered: a decision taken at an edge is visible right after that edge.
module scan_dec
    import scan_pkg::*;
#(
    parameter int SEL_W     = 4,
    parameter int NUM_CH    = 16,
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  clk,
    input  logic                  resetL,
    input  logic                  enable,
    input  logic                  scanMode,
    input  logic [SEL_W-1:0]      manSel,
    output logic [(1<<SEL_W)-1:0] selOut,
    output logic [SEL_W-1:0]      curSel,
    output logic                  wrap,
    output logic                  badSel
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BK_W  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [BK_W-1:0]  BLANK_LAST = BK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]   NUM_CH_W   = (SEL_W + 1)'(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > (1 << SEL_W)) begin : g_chk_num_ch
        $error("scan_dec: NUM_CH must lie in 1..2**SEL_W");
    end
    if (DWELL < 1) begin : g_chk_dwell
        $error("scan_dec: DWELL must be at least 1");
    end

    scan_state_e      state_q,  state_d;
    logic [SEL_W-1:0] curSel_q, curSel_d;
    logic [DW_W-1:0]  dwell_q,  dwell_d;
    logic [BK_W-1:0]  blank_q,  blank_d;
    logic [OUT_W-1:0] selOut_q, selOut_d;
    logic             wrap_q,   wrap_d;
    logic             badSel_q, badSel_d;

    logic             sel_en;
    logic             man_ok;

    // State and output registers
    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            state_q  <= ST_IDLE;
            curSel_q <= '0;
            dwell_q  <= '0;
            blank_q  <= '0;
            selOut_q <= '0;
            wrap_q   <= 1'b0;
            badSel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            curSel_q <= curSel_d;
            dwell_q  <= dwell_d;
            blank_q  <= blank_d;
            selOut_q <= selOut_d;
            wrap_q   <= wrap_d;
            badSel_q <= badSel_d;
        end
    end

    // Next-state: enable and mode override the scan timing; wrap only fires on a real advance
    always_comb begin
        state_d  = state_q;
        curSel_d = curSel_q;
        dwell_d  = dwell_q;
        blank_d  = blank_q;
        wrap_d   = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            dwell_d = '0;
            blank_d = '0;
        end else if (scanMode == MANUAL) begin
            state_d  = ST_MANUAL;
            curSel_d = manSel;
            dwell_d  = '0;
            blank_d  = '0;
        end else begin
            unique case (state_q)
                ST_DRIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        blank_d = '0;
                        if (BLANK_CYC > 0) begin
                            state_d = ST_BLANK;
                        end else begin
                            state_d = ST_DRIVE;
                            if (curSel_q == LAST_CH) begin
                                curSel_d = '0;
                                wrap_d   = 1'b1;
                            end else begin
                                curSel_d = curSel_q + 1'b1;
                            end
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        dwell_d = '0;
                        blank_d = '0;
                        if (curSel_q == LAST_CH) begin
                            curSel_d = '0;
                            wrap_d   = 1'b1;
                        end else begin
                            curSel_d = curSel_q + 1'b1;
                        end
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
                default: begin
                    // Fresh scan entry from IDLE or MANUAL starts at channel 0 without a wrap
                    state_d  = ST_DRIVE;
                    curSel_d = '0;
                    dwell_d  = '0;
                    blank_d  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_comb begin
        man_ok   = ({1'b0, curSel_d} < NUM_CH_W);
        sel_en   = (state_d == ST_DRIVE) || ((state_d == ST_MANUAL) && man_ok);
        badSel_d = (state_d == ST_MANUAL) && !man_ok;
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_onehot_dec (
        .sel    (curSel_d),
        .en     (sel_en),
        .onehot (selOut_d)
    );

    assign selOut = selOut_q;
    assign curSel = curSel_q;
    assign wrap   = wrap_q;
    assign badSel = badSel_q;

endmodule : scan_dec

// File: tb/tb_scan_dec.sv
// Bench for scan_dec: four parameterisations driven from one sequence, expectations queued per cycle.
module tb_scan_dec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    // A: SEL_W=2 NUM_CH=3 DWELL=4 BLANK_CYC=1
    logic       a_en = 0, a_mode = 0;
    logic [1:0] a_man = '0;
    logic [3:0] a_sel;
    logic [1:0] a_cur;
    logic       a_wrap, a_bad;
    // B: SEL_W=4 NUM_CH=10 DWELL=3 BLANK_CYC=1
    logic        b_en = 0, b_mode = 0;
    logic [3:0]  b_man = '0;
    logic [15:0] b_sel;
    logic [3:0]  b_cur;
    logic        b_wrap, b_bad;
    // C: SEL_W=1 NUM_CH=2 DWELL=3 BLANK_CYC=0
    logic       c_en = 0, c_mode = 0;
    logic [0:0] c_man = '0;
    logic [1:0] c_sel;
    logic [0:0] c_cur;
    logic       c_wrap, c_bad;
    // D: SEL_W=1 NUM_CH=1 DWELL=2 BLANK_CYC=1
    logic       d_en = 0, d_mode = 0;
    logic [0:0] d_man = '0;
    logic [1:0] d_sel;
    logic [0:0] d_cur;
    logic       d_wrap, d_bad;

    scan_dec #(.SEL_W(2), .NUM_CH(3), .DWELL(4), .BLANK_CYC(1)) u_a (
        .clk(clk), .resetL(rst_n), .enable(a_en), .scanMode(a_mode), .manSel(a_man),
        .selOut(a_sel), .curSel(a_cur), .wrap(a_wrap), .badSel(a_bad));
    scan_dec #(.SEL_W(4), .NUM_CH(10), .DWELL(3), .BLANK_CYC(1)) u_b (
        .clk(clk), .resetL(rst_n), .enable(b_en), .scanMode(b_mode), .manSel(b_man),
        .selOut(b_sel), .curSel(b_cur), .wrap(b_wrap), .badSel(b_bad));
    scan_dec #(.SEL_W(1), .NUM_CH(2), .DWELL(3), .BLANK_CYC(0)) u_c (
        .clk(clk), .resetL(rst_n), .enable(c_en), .scanMode(c_mode), .manSel(c_man),
        .selOut(c_sel), .curSel(c_cur), .wrap(c_wrap), .badSel(c_bad));
    scan_dec #(.SEL_W(1), .NUM_CH(1), .DWELL(2), .BLANK_CYC(1)) u_d (
        .clk(clk), .resetL(rst_n), .enable(d_en), .scanMode(d_mode), .manSel(d_man),
        .selOut(d_sel), .curSel(d_cur), .wrap(d_wrap), .badSel(d_bad));

    typedef struct packed {
        logic [15:0] sel;
        logic [3:0]  cur;
        logic        wrap;
        logic        bad;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Ideal scan timeline: k counts clocks since scan entry, each channel owns dw+bl clocks
    function automatic exp_t exp_scan(int k, int nch, int dw, int bl);
        exp_t e;
        int per = dw + bl;
        int seg = k % per;
        int ch  = (k / per) % nch;
        e.sel  = (seg < dw) ? (16'd1 << ch) : 16'd0;
        e.cur  = 4'(ch);
        e.wrap = (seg == 0) && (ch == 0) && (k > 0);
        e.bad  = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(logic [15:0] sel, logic [3:0] cur, logic wrap, logic bad);
        exp_t e;
        e.sel = sel; e.cur = cur; e.wrap = wrap; e.bad = bad;
        return e;
    endfunction

    task automatic test_reset();
        exp_t got, e;
        #1 rst_n = 1'b0;
        #3;
        e = mk(16'h0, 4'h0, 1'b0, 1'b0);
        got = mk(16'(a_sel), 4'(a_cur), a_wrap, a_bad);
        n_checks++;
        if (got !== e) $display("FAIL reset_a got %h want %h", got, e); else n_pass++;
        got = mk(b_sel, b_cur, b_wrap, b_bad);
        n_checks++;
        if (got !== e) $display("FAIL reset_b got %h want %h", got, e); else n_pass++;
        got = mk(16'(c_sel), 4'(c_cur), c_wrap, c_bad);
        n_checks++;
        if (got !== e) $display("FAIL reset_c got %h want %h", got, e); else n_pass++;
        got = mk(16'(d_sel), 4'(d_cur), d_wrap, d_bad);
        n_checks++;
        if (got !== e) $display("FAIL reset_d got %h want %h", got, e); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scan_seq();
        exp_t got, e;
        a_mode = 1'b1;
        a_en   = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            sb.push_back(exp_scan(k, 3, 4, 1));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = mk(16'(a_sel), 4'(a_cur), a_wrap, a_bad);
            n_checks++;
            if (got !== e) $display("FAIL scan_seq k=%0d got %h want %h", k, got, e); else n_pass++;
        end
    endtask

    task automatic test_enable_drop_mode_switch();
        exp_t got, e;
        // A is now in the blank gap after channel 1
        a_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(16'h0, 4'h1, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = mk(16'(a_sel), 4'(a_cur), a_wrap, a_bad);
            n_checks++;
            if (got !== e) $display("FAIL enable_drop i=%0d got %h want %h", i, got, e); else n_pass++;
        end
        a_mode = 1'b0;
        a_man  = 2'd2;
        a_en   = 1'b1;
        sb.push_back(mk(16'h4, 4'h2, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front();
        got = mk(16'(a_sel), 4'(a_cur), a_wrap, a_bad);
        n_checks++;
        if (got !== e) $display("FAIL reenable_manual got %h want %h", got, e); else n_pass++;
        a_mode = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            sb.push_back(exp_scan(k, 3, 4, 1));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = mk(16'(a_sel), 4'(a_cur), a_wrap, a_bad);
            n_checks++;
            if (got !== e) $display("FAIL mode_switch_scan k=%0d got %h want %h", k, got, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t got, e;
        // A is driving channel 1; reset must clear outputs without a clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        e = mk(16'h0, 4'h0, 1'b0, 1'b0);
        got = mk(16'(a_sel), 4'(a_cur), a_wrap, a_bad);
        n_checks++;
        if (got !== e) $display("FAIL reset_mid_scan got %h want %h", got, e); else n_pass++;
        a_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual_decode();
        exp_t got, e;
        b_mode = 1'b0;
        b_en   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_man = 4'(i);
            sb.push_back(mk((i < 10) ? (16'd1 << i) : 16'd0, 4'(i), 1'b0, (i >= 10)));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = mk(b_sel, b_cur, b_wrap, b_bad);
            n_checks++;
            if (got !== e) $display("FAIL manual_decode sel=%0d got %h want %h", i, got, e); else n_pass++;
        end
        b_en = 1'b0;
        sb.push_back(mk(16'h0, 4'hf, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front();
        got = mk(b_sel, b_cur, b_wrap, b_bad);
        n_checks++;
        if (got !== e) $display("FAIL manual_disable got %h want %h", got, e); else n_pass++;
    endtask

    task automatic test_no_blank();
        exp_t got, e;
        c_mode = 1'b1;
        c_en   = 1'b1;
        for (int k = 0; k < 14; k++) begin
            sb.push_back(exp_scan(k, 2, 3, 0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = mk(16'(c_sel), 4'(c_cur), c_wrap, c_bad);
            n_checks++;
            if (got !== e) $display("FAIL no_blank k=%0d got %h want %h", k, got, e); else n_pass++;
        end
        c_en = 1'b0;
    endtask

    task automatic test_single_channel();
        exp_t got, e;
        d_mode = 1'b1;
        d_en   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sb.push_back(exp_scan(k, 1, 2, 1));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = mk(16'(d_sel), 4'(d_cur), d_wrap, d_bad);
            n_checks++;
            if (got !== e) $display("FAIL single_ch k=%0d got %h want %h", k, got, e); else n_pass++;
        end
        d_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_seq();
        test_enable_drop_mode_switch();
        test_reset_mid_scan();
        test_manual_decode();
        test_no_blank();
        test_single_channel();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_scan_dec
